// File: rtl/zebu_rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// zebu_rst_pkg
// Shared definitions for the ZeBu reset sequencer: FSM state encoding,
// default parameter set and a saturating counter helper.
// No ports (package).
// -----------------------------------------------------------------------------
package zebu_rst_pkg;

  typedef enum logic [1:0] {
    ST_PRE     = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  localparam int DEF_NUM_CH        = 2;
  localparam int DEF_PRE_CYCLES    = 5;
  localparam int DEF_ASSERT_CYCLES = 20;
  localparam int DEF_STAGE_GAP     = 4;
  localparam int DEF_WDT_CYCLES    = 1024;
  localparam int DEF_CNT_W         = 16;

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/zebu_rst_seq_if.sv
// -----------------------------------------------------------------------------
// zebu_rst_seq_if
// Control/status bundle of the reset sequencer.
//   req        re-sequence request
//   hb         DUT heartbeat, clears the watchdog
//   wdt_en     watchdog enable
//   rst_n_out  per-channel active-low resets (NUM_CH wide)
//   busy       high whenever the sequencer is not in RUN
//   seq_done   one-cycle pulse on release of the last channel
//   wdt_fire   one-cycle pulse on watchdog expiry
//   rst_count  completed sequences, saturating at 255
// master: the side driving requests (testbench / emulation top).
// slave:  the sequencer itself.
// -----------------------------------------------------------------------------
interface zebu_rst_seq_if #(
  parameter int NUM_CH = 2
);

  logic              req;
  logic              hb;
  logic              wdt_en;
  logic [NUM_CH-1:0] rst_n_out;
  logic              busy;
  logic              seq_done;
  logic              wdt_fire;
  logic [7:0]        rst_count;

  modport master (
    output req, hb, wdt_en,
    input  rst_n_out, busy, seq_done, wdt_fire, rst_count
  );

  modport slave (
    input  req, hb, wdt_en,
    output rst_n_out, busy, seq_done, wdt_fire, rst_count
  );

endinterface

// File: rtl/zebu_rst_seq_wdt.sv
// -----------------------------------------------------------------------------
// zebu_wdt
// Heartbeat watchdog counter.
//   clk, resetn  clock and synchronous active-low reset
//   en           count enable (watchdog enabled and sequencer in RUN)
//   hb           heartbeat, clears the count
//   tc           combinational terminal-count pulse, consumed on the same edge
// -----------------------------------------------------------------------------
module zebu_wdt #(
  parameter int CNT_W      = 16,
  parameter int WDT_CYCLES = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic hb,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WDT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // A heartbeat on the expiry edge suppresses the pulse.
  assign tc = en && !hb && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (!en || hb || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/zebu_rst_seq.sv
// -----------------------------------------------------------------------------
// zebu_rst_seq
// Multi-channel reset sequencer: hold outputs high, assert all channels,
// then release them in order with a programmable gap. Re-sequences on
// request or on heartbeat watchdog expiry.
//   clk     emulator clock
//   resetn  synchronous active-low reset
//   bus     zebu_rst_seq_if.slave (requests in, channel resets/status out)
// -----------------------------------------------------------------------------
module zebu_rst_seq
  import zebu_rst_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int PRE_CYCLES    = DEF_PRE_CYCLES,
  parameter int ASSERT_CYCLES = DEF_ASSERT_CYCLES,
  parameter int STAGE_GAP     = DEF_STAGE_GAP,
  parameter int WDT_CYCLES    = DEF_WDT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           resetn,
  zebu_rst_seq_if.slave  bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0] PRE_LAST    = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
  // Index of the channel released just before the last one.
  localparam logic [CH_W-1:0]  PENULT_IDX  = CH_W'(NUM_CH - 2);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CH_W-1:0]   ch_idx;
  logic [NUM_CH-1:0] rst_n_q;
  logic              busy_q;
  logic              seq_done_q;
  logic              wdt_fire_q;
  logic [7:0]        rst_count_q;
  logic              wdt_tc;

  zebu_wdt #(
    .CNT_W      (CNT_W),
    .WDT_CYCLES (WDT_CYCLES)
  ) u_wdt (
    .clk    (clk),
    .resetn (resetn),
    .en     (bus.wdt_en && (state == ST_RUN)),
    .hb     (bus.hb),
    .tc     (wdt_tc)
  );

  // Sequencer FSM. A request outranks every state transition except in PRE,
  // which also makes it win over a simultaneous watchdog expiry. Channels are
  // released in ascending order, so the next release shifts one more '1' in
  // from the bottom of the output mask.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_PRE;
      cnt         <= '0;
      ch_idx      <= '0;
      rst_n_q     <= '1;
      busy_q      <= 1'b1;
      seq_done_q  <= 1'b0;
      wdt_fire_q  <= 1'b0;
      rst_count_q <= '0;
    end else begin
      seq_done_q <= 1'b0;
      wdt_fire_q <= 1'b0;
      if (bus.req && (state != ST_PRE)) begin
        state   <= ST_ASSERT;
        cnt     <= '0;
        ch_idx  <= '0;
        rst_n_q <= '0;
        busy_q  <= 1'b1;
      end else begin
        case (state)
          ST_PRE: begin
            if (cnt == PRE_LAST) begin
              state   <= ST_ASSERT;
              cnt     <= '0;
              rst_n_q <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_ASSERT: begin
            if (cnt == ASSERT_LAST) begin
              cnt    <= '0;
              ch_idx <= '0;
              if (NUM_CH == 1) begin
                state       <= ST_RUN;
                rst_n_q     <= '1;
                busy_q      <= 1'b0;
                seq_done_q  <= 1'b1;
                rst_count_q <= sat_inc(rst_count_q);
              end else begin
                state   <= ST_RELEASE;
                rst_n_q <= NUM_CH'(1);
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_RELEASE: begin
            if (cnt == GAP_LAST) begin
              cnt     <= '0;
              ch_idx  <= ch_idx + CH_W'(1);
              rst_n_q <= NUM_CH'({rst_n_q, 1'b1});
              if (ch_idx == PENULT_IDX) begin
                state       <= ST_RUN;
                busy_q      <= 1'b0;
                seq_done_q  <= 1'b1;
                rst_count_q <= sat_inc(rst_count_q);
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_RUN: begin
            if (wdt_tc) begin
              state      <= ST_ASSERT;
              cnt        <= '0;
              ch_idx     <= '0;
              rst_n_q    <= '0;
              busy_q     <= 1'b1;
              wdt_fire_q <= 1'b1;
            end
          end
          default: state <= ST_PRE;
        endcase
      end
    end
  end

  assign bus.rst_n_out = rst_n_q;
  assign bus.busy      = busy_q;
  assign bus.seq_done  = seq_done_q;
  assign bus.wdt_fire  = wdt_fire_q;
  assign bus.rst_count = rst_count_q;

endmodule

// File: tb/tb_zebu_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_zebu_rst_seq
// Scoreboard bench for the reset sequencer. Stimulus pushes every expected
// output change (edge number + output snapshot); a negedge monitor pops the
// matching entry whenever a DUT's outputs change. Two DUTs: a two-channel one
// with a 16-cycle watchdog and a single-channel one.
// -----------------------------------------------------------------------------
module tb_zebu_rst_seq;

  typedef struct {
    int          dut;
    int          cyc;
    logic [12:0] snap;
  } exp_t;

  logic clk = 1'b0;
  logic resetn0;
  logic resetn1;
  int   cyc = 0;
  int   n_compared = 0;
  int   n_mismatched = 0;

  exp_t        exp_q[$];
  logic [12:0] prev_snap [2];

  zebu_rst_seq_if #(.NUM_CH(2)) if0 ();
  zebu_rst_seq_if #(.NUM_CH(1)) if1 ();

  zebu_rst_seq #(.NUM_CH(2), .WDT_CYCLES(16)) u_dut0 (
    .clk    (clk),
    .resetn (resetn0),
    .bus    (if0.slave)
  );

  zebu_rst_seq #(.NUM_CH(1)) u_dut1 (
    .clk    (clk),
    .resetn (resetn1),
    .bus    (if1.slave)
  );

  // Free-running clock and edge counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record one expected output change at absolute edge number 'at'.
  task automatic push_exp(input int dut, input int at, input logic [1:0] rst,
                          input logic busy, input logic sd, input logic wf,
                          input logic [7:0] cnt);
    exp_t e;
    e.dut  = dut;
    e.cyc  = at;
    e.snap = {rst, busy, sd, wf, cnt};
    exp_q.push_back(e);
  endtask

  // Advance n clock edges; inputs set afterwards are sampled at the next edge.
  task automatic apply_stimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare a changed output snapshot against the oldest pending expectation.
  task automatic check_output(input int dut, input logic [12:0] snap);
    int   idx[$];
    exp_t e;
    if (snap === prev_snap[dut]) return;
    prev_snap[dut] = snap;
    n_compared++;
    idx = exp_q.find_first_index(item) with (item.dut == dut);
    if (idx.size() == 0) begin
      n_mismatched++;
      $display("[TB] FAIL dut%0d unexpected_change at edge %0d: got snap=%h, required no change",
               dut, cyc, snap);
    end else begin
      e = exp_q[idx[0]];
      exp_q.delete(idx[0]);
      if ((snap !== e.snap) || (cyc != e.cyc)) begin
        n_mismatched++;
        $display("[TB] FAIL dut%0d change: got edge=%0d snap=%h, required edge=%0d snap=%h",
                 dut, cyc, snap, e.cyc, e.snap);
      end
    end
  endtask

  // Monitor: snapshot = {rst_n_out[1:0], busy, seq_done, wdt_fire, rst_count}.
  always @(negedge clk) begin
    check_output(0, {if0.rst_n_out, if0.busy, if0.seq_done, if0.wdt_fire, if0.rst_count});
    check_output(1, {1'b0, if1.rst_n_out, if1.busy, if1.seq_done, if1.wdt_fire, if1.rst_count});
  end

  initial begin
    int b, t, l, q, r, c;
    resetn0 = 1'b0;
    resetn1 = 1'b0;
    if0.req = 1'b0; if0.hb = 1'b0; if0.wdt_en = 1'b0;
    if1.req = 1'b0; if1.hb = 1'b0; if1.wdt_en = 1'b0;

    // Reset values seen after the first edge on both DUTs.
    push_exp(0, 1, 2'b11, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(1, 1, 2'b01, 1'b1, 1'b0, 1'b0, 8'd0);
    apply_stimulus(3);

    // Power-up sequence with defaults.
    b = cyc;
    resetn0 = 1'b1;
    push_exp(0, b + 5,  2'b00, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(0, b + 25, 2'b01, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(0, b + 29, 2'b11, 1'b0, 1'b1, 1'b0, 8'd1);
    push_exp(0, b + 30, 2'b11, 1'b0, 1'b0, 1'b0, 8'd1);
    apply_stimulus(35);

    // Watchdog expiry without heartbeat, then the resequence.
    t = cyc;
    if0.wdt_en = 1'b1;
    push_exp(0, t + 16, 2'b00, 1'b1, 1'b0, 1'b1, 8'd1);
    push_exp(0, t + 17, 2'b00, 1'b1, 1'b0, 1'b0, 8'd1);
    push_exp(0, t + 36, 2'b01, 1'b1, 1'b0, 1'b0, 8'd1);
    push_exp(0, t + 40, 2'b11, 1'b0, 1'b1, 1'b0, 8'd2);
    push_exp(0, t + 41, 2'b11, 1'b0, 1'b0, 1'b0, 8'd2);
    apply_stimulus(41);

    // Heartbeat every 10 cycles for 200 cycles: no output may change.
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(9);
      if0.hb = 1'b1;
      apply_stimulus(1);
      if0.hb = 1'b0;
    end
    l = cyc;

    // Heartbeat exactly on the expiry edge: no fire.
    apply_stimulus(15);
    if0.hb = 1'b1;
    apply_stimulus(1);
    if0.hb = 1'b0;

    // Request on the next expiry edge: request wins, wdt_fire stays low.
    apply_stimulus(15);
    push_exp(0, l + 32, 2'b00, 1'b1, 1'b0, 1'b0, 8'd2);
    push_exp(0, l + 52, 2'b01, 1'b1, 1'b0, 1'b0, 8'd2);
    push_exp(0, l + 56, 2'b11, 1'b0, 1'b1, 1'b0, 8'd3);
    push_exp(0, l + 57, 2'b11, 1'b0, 1'b0, 1'b0, 8'd3);
    if0.req = 1'b1;
    apply_stimulus(1);
    if0.req = 1'b0;
    if0.wdt_en = 1'b0;
    apply_stimulus(30);

    // Request from RUN, then again two cycles after channel 0 release.
    q = cyc + 1;
    push_exp(0, q,      2'b00, 1'b1, 1'b0, 1'b0, 8'd3);
    push_exp(0, q + 20, 2'b01, 1'b1, 1'b0, 1'b0, 8'd3);
    push_exp(0, q + 22, 2'b00, 1'b1, 1'b0, 1'b0, 8'd3);
    push_exp(0, q + 42, 2'b01, 1'b1, 1'b0, 1'b0, 8'd3);
    push_exp(0, q + 46, 2'b11, 1'b0, 1'b1, 1'b0, 8'd4);
    push_exp(0, q + 47, 2'b11, 1'b0, 1'b0, 1'b0, 8'd4);
    if0.req = 1'b1;
    apply_stimulus(1);
    if0.req = 1'b0;
    apply_stimulus(21);
    if0.req = 1'b1;
    apply_stimulus(1);
    if0.req = 1'b0;
    apply_stimulus(30);

    // One-cycle resetn pulse mid-ASSERT, then a fresh sequence from PRE.
    r = cyc + 1;
    push_exp(0, r,      2'b00, 1'b1, 1'b0, 1'b0, 8'd4);
    push_exp(0, r + 5,  2'b11, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(0, r + 10, 2'b00, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(0, r + 30, 2'b01, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(0, r + 34, 2'b11, 1'b0, 1'b1, 1'b0, 8'd1);
    push_exp(0, r + 35, 2'b11, 1'b0, 1'b0, 1'b0, 8'd1);
    if0.req = 1'b1;
    apply_stimulus(1);
    if0.req = 1'b0;
    apply_stimulus(4);
    resetn0 = 1'b0;
    apply_stimulus(1);
    resetn0 = 1'b1;
    apply_stimulus(35);

    // Single-channel DUT: seq_done coincides with the release after ASSERT.
    c = cyc;
    resetn1 = 1'b1;
    push_exp(1, c + 5,  2'b00, 1'b1, 1'b0, 1'b0, 8'd0);
    push_exp(1, c + 25, 2'b01, 1'b0, 1'b1, 1'b0, 8'd1);
    push_exp(1, c + 26, 2'b01, 1'b0, 1'b0, 1'b0, 8'd1);
    apply_stimulus(35);

    // Any expectation still queued is a change that never happened.
    while (exp_q.size() > 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL dut%0d missing_change: got none, required edge=%0d snap=%h",
               exp_q[0].dut, exp_q[0].cyc, exp_q[0].snap);
      void'(exp_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
